// File: rtl/iir_ff_pkg.sv
// Shared definitions for the IIR filter stages: FSM encoding, width helper and the
// packed-coefficient layout (coefficient k lives at [COEFF_WIDTH*k +: COEFF_WIDTH]).
package iir_ff_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } iir_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

  function automatic int unsigned coeff_base(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Rounds a fixed-point accumulator (half toward +inf), drops FRAC fraction bits and
// saturates the result to a signed PRECISION-bit word, flagging any clamp.
module iir_round_sat #(
  parameter int unsigned ACC_WIDTH = 42,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned FRAC      = 14
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [PRECISION-1:0] y_o,
  output logic                        ovf_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned SW = ACC_WIDTH + 1;
  localparam logic signed [SW-1:0] HalfV = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MaxV  = {{(SW - PRECISION + 1){1'b0}}, {(PRECISION - 1){1'b1}}};
  localparam logic signed [SW-1:0] MinV  = {{(SW - PRECISION + 1){1'b1}}, {(PRECISION - 1){1'b0}}};

  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] shr;

  always_comb begin
    rnd   = $signed({acc_i[ACC_WIDTH-1], acc_i}) + HalfV;
    shr   = rnd >>> FRAC;
    y_o   = shr[PRECISION-1:0];
    ovf_o = 1'b0;
    if (shr > MaxV) begin
      y_o   = MaxV[PRECISION-1:0];
      ovf_o = 1'b1;
    end else if (shr < MinV) begin
      y_o   = MinV[PRECISION-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/iir_ff.sv
// Feedforward (b-coefficient) IIR stage: y[n] = sum b_k * x[n-k], evaluated one tap per
// cycle on a single multiplier-accumulator, with a valid/ready sample handshake.
module iir_ff
  import iir_ff_pkg::*;
#(
  parameter int unsigned N           = 2,
  parameter int unsigned PRECISION   = 24,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned COEFF_FRAC  = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x_valid,
  input  logic signed [PRECISION-1:0]    x,
  input  logic [COEFF_WIDTH*(N+1)-1:0]   packed_b_coeffs,
  output logic                           ready,
  output logic                           y_valid,
  output logic signed [PRECISION-1:0]    y,
  output logic                           overflow
);

  localparam int unsigned ACC_WIDTH = PRECISION + COEFF_WIDTH + clog2(N + 1);
  localparam int unsigned PW        = PRECISION + COEFF_WIDTH;
  localparam int unsigned TapW      = (clog2(N + 1) > 0) ? clog2(N + 1) : 1;

  iir_state_e                        state_q, state_d;
  logic signed [PRECISION-1:0]       x_d_q [N+1];
  logic signed [PRECISION-1:0]       x_d_d [N+1];
  logic [COEFF_WIDTH*(N+1)-1:0]      b_q, b_d;
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [TapW-1:0]                   tap_q, tap_d;
  logic signed [PRECISION-1:0]       y_q, y_d;
  logic                              ovf_q, ovf_d;
  logic                              y_valid_q, y_valid_d;

  logic signed [PRECISION-1:0]       x_sel;
  logic signed [COEFF_WIDTH-1:0]     b_sel;
  logic signed [PW-1:0]              x_ext, b_ext, prod;
  logic signed [PRECISION-1:0]       rs_y;
  logic                              rs_ovf;

  iir_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .PRECISION (PRECISION),
    .FRAC      (COEFF_FRAC)
  ) u_round_sat (
    .acc_i (acc_q),
    .y_o   (rs_y),
    .ovf_o (rs_ovf)
  );

  always_comb begin
    x_sel = x_d_q[tap_q];
    b_sel = b_q[coeff_base(32'(tap_q), COEFF_WIDTH) +: COEFF_WIDTH];
    x_ext = PW'(x_sel);
    b_ext = PW'(b_sel);
    prod  = x_ext * b_ext;
  end

  always_comb begin
    state_d   = state_q;
    x_d_d     = x_d_q;
    b_d       = b_q;
    acc_d     = acc_q;
    tap_d     = tap_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    y_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (x_valid) begin
          for (int k = N; k >= 1; k--) begin
            x_d_d[k] = x_d_q[k-1];
          end
          x_d_d[0] = x;
          b_d      = packed_b_coeffs;
          acc_d    = '0;
          tap_d    = '0;
          state_d  = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        tap_d = tap_q + 1'b1;
        if (tap_q == TapW'(N)) begin
          state_d = StOut;
        end
      end
      StOut: begin
        y_d       = rs_y;
        ovf_d     = rs_ovf;
        y_valid_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      for (int k = 0; k <= N; k++) begin
        x_d_q[k] <= '0;
      end
      b_q       <= '0;
      acc_q     <= '0;
      tap_q     <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_d_q     <= x_d_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      tap_q     <= tap_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign y_valid  = y_valid_q;
  assign y        = y_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_iir_ff.sv
// Directed bench for iir_ff (N=2, 24-bit samples, Q2.14 coefficients).
module tb_iir_ff;

  logic               clk;
  logic               rst_n;
  logic               x_valid;
  logic signed [23:0] x;
  logic [47:0]        packed_b_coeffs;
  logic               ready;
  logic               y_valid;
  logic signed [23:0] y;
  logic               overflow;

  int vectors;
  int miscompares;
  int cyc;
  int acc_cyc;

  iir_ff #(
    .N           (2),
    .PRECISION   (24),
    .COEFF_WIDTH (16),
    .COEFF_FRAC  (14)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .x_valid         (x_valid),
    .x               (x),
    .packed_b_coeffs (packed_b_coeffs),
    .ready           (ready),
    .y_valid         (y_valid),
    .y               (y),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] pk(input int b0, input int b1, input int b2);
    logic [15:0] c0, c1, c2;
    c0 = 16'(b0);
    c1 = 16'(b1);
    c2 = 16'(b2);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    x_valid = 1'b0;
    x       = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one sample on a ready cycle; returns #1 after the accept edge.
  task automatic start(input int val);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'sd1);
    x_valid = 1'b1;
    x       = 24'(val);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    x_valid = 1'b0;
  endtask

  // Wait (bounded) for y_valid and check value, overflow and latency.
  task automatic finish(input string tag, input int exp_y, input logic exp_ovf);
    int n;
    n = 0;
    while (!y_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_yvalid"}, 32'(y_valid), 32'sd1);
    chk({tag, "_y"}, y, exp_y);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_lat"}, cyc - acc_cyc, 32'sd4);
  endtask

  initial begin
    int rdy_cnt, yv_cnt, first_rdy, second_rdy;
    vectors         = 0;
    miscompares     = 0;
    cyc             = 0;
    acc_cyc         = 0;
    rst_n           = 1'b0;
    x_valid         = 1'b0;
    x               = '0;
    packed_b_coeffs = '0;
    do_reset();
    #1;
    chk("rst_ready", 32'(ready), 32'sd1);
    chk("rst_yvalid", 32'(y_valid), 32'sd0);
    chk("rst_y", y, 32'sd0);
    chk("rst_ovf", 32'(overflow), 32'sd0);

    // Impulse through b = {1.0, 0, 0}
    packed_b_coeffs = pk(16384, 0, 0);
    start(1000); finish("imp0", 1000, 1'b0);
    start(0);    finish("imp1", 0, 1'b0);
    start(0);    finish("imp2", 0, 1'b0);

    // Moving average and difference
    do_reset();
    packed_b_coeffs = pk(8192, 8192, 0);
    start(1000); finish("avg0", 500, 1'b0);
    start(1000); finish("avg1", 1000, 1'b0);
    start(1000); finish("avg2", 1000, 1'b0);
    do_reset();
    packed_b_coeffs = pk(8192, 0, -8192);
    start(1000); finish("dif0", 500, 1'b0);
    start(1000); finish("dif1", 500, 1'b0);
    start(1000); finish("dif2", 0, 1'b0);

    // Rounding half toward +inf
    do_reset();
    packed_b_coeffs = pk(8192, 0, 0);
    start(3);  finish("rnd_p3", 2, 1'b0);
    start(-3); finish("rnd_m3", -1, 1'b0);
    start(1);  finish("rnd_p1", 1, 1'b0);
    start(-1); finish("rnd_m1", 0, 1'b0);

    // Saturation
    do_reset();
    packed_b_coeffs = pk(32767, 0, 0);
    start(8388607);  finish("sat_pos", 8388607, 1'b1);
    start(-8388608); finish("sat_neg", -8388608, 1'b1);
    start(100);      finish("sat_clr", 200, 1'b0);

    // x_valid held high: accepts only on ready cycles, one per 5 clocks
    do_reset();
    packed_b_coeffs = pk(16384, 0, 0);
    @(negedge clk);
    x_valid    = 1'b1;
    x          = 24'sd7;
    rdy_cnt    = 0;
    yv_cnt     = 0;
    first_rdy  = -1;
    second_rdy = -1;
    for (int i = 0; i < 12; i++) begin
      if (ready) begin
        rdy_cnt++;
        if (first_rdy < 0) first_rdy = i;
        else if (second_rdy < 0) second_rdy = i;
      end
      if (y_valid) yv_cnt++;
      @(negedge clk);
    end
    x_valid = 1'b0;
    chk("hold_accepts", rdy_cnt, 32'sd3);
    chk("hold_outputs", yv_cnt, 32'sd2);
    chk("hold_spacing", second_rdy - first_rdy, 32'sd5);
    chk("hold_y", y, 32'sd7);
    repeat (8) @(negedge clk);

    // Sample pulsed during MAC is dropped
    do_reset();
    packed_b_coeffs = pk(16384, 16384, 0);
    start(1000);
    @(negedge clk);
    x_valid = 1'b1;
    x       = 24'sd5000;
    @(negedge clk);
    x_valid = 1'b0;
    finish("drop0", 1000, 1'b0);
    start(0); finish("drop1", 1000, 1'b0);
    start(0); finish("drop2", 0, 1'b0);

    // Coefficients changed mid-MAC: snapshot wins
    packed_b_coeffs = pk(16384, 0, 0);
    start(300);
    packed_b_coeffs = pk(8192, 8192, 8192);
    finish("snap", 300, 1'b0);

    // Reset in the middle of MAC
    do_reset();
    packed_b_coeffs = pk(16384, 16384, 0);
    start(1000); finish("prerst", 1000, 1'b0);
    start(2000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'sd1);
    chk("midrst_y", y, 32'sd0);
    chk("midrst_yvalid", 32'(y_valid), 32'sd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    yv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (y_valid) yv_cnt++;
    end
    chk("midrst_noout", yv_cnt, 32'sd0);
    start(1000); finish("post0", 1000, 1'b0);
    start(0);    finish("post1", 1000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
